// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit feeding the HI/LO pair: one shift-add or restoring step per cycle.
// Define MULDIV_MADD_EN to add the MADD/MADDU/MSUB/MSUBU accumulate ops (codes 8-11).
module ex_muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             Start,
   input  logic [3:0]       Op,
   input  logic [WIDTH-1:0] Rs,
   input  logic [WIDTH-1:0] Rt,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

   state_t             state_reg;
   logic [CW-1:0]      cnt_reg;
   logic [2*WIDTH-1:0] acc_reg;
   logic [WIDTH-1:0]   opnd_reg;
   logic               div_reg, neg_res_reg, neg_rem_reg, div0_reg;
   logic               busy_reg, done_reg;
   logic [WIDTH-1:0]   hi_reg, lo_reg;
`ifdef MULDIV_MADD_EN
   logic               acc_en_reg, acc_sub_reg;
   logic               is_macc, is_msub;
`endif
   logic               is_long, is_div, is_signed, is_mthi, is_mtlo;

   always_comb begin
      is_long   = 1'b0;
      is_div    = 1'b0;
      is_signed = 1'b0;
      is_mthi   = 1'b0;
      is_mtlo   = 1'b0;
`ifdef MULDIV_MADD_EN
      is_macc   = 1'b0;
      is_msub   = 1'b0;
`endif
      case (Op)
         4'd1: begin is_long = 1'b1; is_signed = 1'b1; end
         4'd2: is_long = 1'b1;
         4'd3: begin is_long = 1'b1; is_div = 1'b1; is_signed = 1'b1; end
         4'd4: begin is_long = 1'b1; is_div = 1'b1; end
         4'd5: is_mthi = 1'b1;
         4'd6: is_mtlo = 1'b1;
`ifdef MULDIV_MADD_EN
         4'd8:  begin is_long = 1'b1; is_macc = 1'b1; is_signed = 1'b1; end
         4'd9:  begin is_long = 1'b1; is_macc = 1'b1; end
         4'd10: begin is_long = 1'b1; is_macc = 1'b1; is_msub = 1'b1; is_signed = 1'b1; end
         4'd11: begin is_long = 1'b1; is_macc = 1'b1; is_msub = 1'b1; end
`endif
         default: ;
      endcase
   end

   // Both algorithms run on magnitudes; signs are restored in FIX.
   logic             neg_a, neg_b;
   logic [WIDTH-1:0] mag_a, mag_b;
   assign neg_a = is_signed & Rs[WIDTH-1];
   assign neg_b = is_signed & Rt[WIDTH-1];
   assign mag_a = neg_a ? -Rs : Rs;
   assign mag_b = neg_b ? -Rt : Rt;

   // Multiply: acc = {partial, multiplier}, add-then-shift-right.
   // Divide:   acc = {remainder, dividend/quotient}, shift-left-then-trial-subtract.
   logic [WIDTH:0]     mul_sum, div_shift, div_diff;
   logic [2*WIDTH-1:0] mul_next, div_next;
   logic               q_bit;
   assign mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
   assign mul_next  = {mul_sum, acc_reg[WIDTH-1:1]};
   assign div_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, opnd_reg};
   assign q_bit     = ~div_diff[WIDTH];
   assign div_next  = {(q_bit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]), acc_reg[WIDTH-2:0], q_bit};

   logic [2*WIDTH-1:0] prod, wb;
   logic [WIDTH-1:0]   quo, rem;
   assign prod = neg_res_reg ? -acc_reg : acc_reg;
   assign quo  = div0_reg ? '1 : (neg_res_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0]);
   // A zero divisor leaves the dividend magnitude in the remainder, so HI comes back as Rs.
   assign rem  = neg_rem_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];

   always_comb begin
      wb = div_reg ? {rem, quo} : prod;
`ifdef MULDIV_MADD_EN
      if (acc_en_reg)
         wb = acc_sub_reg ? ({hi_reg, lo_reg} - prod) : ({hi_reg, lo_reg} + prod);
`endif
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_reg   <= S_IDLE;
         cnt_reg     <= '0;
         acc_reg     <= '0;
         opnd_reg    <= '0;
         div_reg     <= 1'b0;
         neg_res_reg <= 1'b0;
         neg_rem_reg <= 1'b0;
         div0_reg    <= 1'b0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         hi_reg      <= '0;
         lo_reg      <= '0;
`ifdef MULDIV_MADD_EN
         acc_en_reg  <= 1'b0;
         acc_sub_reg <= 1'b0;
`endif
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (Start && is_long) begin
                  state_reg   <= S_RUN;
                  busy_reg    <= 1'b1;
                  cnt_reg     <= '0;
                  div_reg     <= is_div;
                  neg_res_reg <= neg_a ^ neg_b;
                  neg_rem_reg <= neg_a;
                  div0_reg    <= is_div & (Rt == '0);
                  acc_reg     <= {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
                  opnd_reg    <= is_div ? mag_b : mag_a;
`ifdef MULDIV_MADD_EN
                  acc_en_reg  <= is_macc;
                  acc_sub_reg <= is_msub;
`endif
               end else if (Start && is_mthi) begin
                  hi_reg <= Rs;
               end else if (Start && is_mtlo) begin
                  lo_reg <= Rs;
               end
            end
            S_RUN: begin
               acc_reg <= div_reg ? div_next : mul_next;
               cnt_reg <= cnt_reg + 1'b1;
               if (cnt_reg == LAST)
                  state_reg <= S_FIX;
            end
            S_FIX: begin
               hi_reg    <= wb[2*WIDTH-1:WIDTH];
               lo_reg    <= wb[WIDTH-1:0];
               state_reg <= S_IDLE;
               busy_reg  <= 1'b0;
               done_reg  <= 1'b1;
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   assign Busy = busy_reg;
   assign Done = done_reg;
   assign HI   = hi_reg;
   assign LO   = lo_reg;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Randomised and directed checks of ex_muldiv_unit against an arithmetic reference model.
module tb_ex_muldiv_unit;
   localparam int W = 32;

   logic         Clk = 1'b0, Rst_n = 1'b1, Start = 1'b0;
   logic [3:0]   Op = 4'd0;
   logic [W-1:0] Rs = '0, Rt = '0;
   logic         Busy, Done;
   logic [W-1:0] HI, LO;

   int           pass_cnt = 0, total_cnt = 0;
   logic [W-1:0] m_hi = '0, m_lo = '0;

   ex_muldiv_unit #(.WIDTH(W)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Op(Op), .Rs(Rs), .Rt(Rt),
      .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
   );

   always #5 Clk = ~Clk;

   // Reference: {HI,LO} after a long op, from plain 64-bit arithmetic.
   function automatic logic [63:0] ref_long(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [63:0] hilo);
      longint     sp;
      logic [63:0] up;
      int         q, r;
      sp = longint'($signed(a)) * longint'($signed(b));
      up = {32'b0, a} * {32'b0, b};
      case (op)
         4'd1: return 64'(sp);
         4'd2: return up;
         4'd3: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
            return {r, q};
         end
         4'd4: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
         4'd8:  return hilo + 64'(sp);
         4'd9:  return hilo + up;
         4'd10: return hilo - 64'(sp);
         4'd11: return hilo - up;
         default: return hilo;
      endcase
   endfunction

   // Issue one long op and watch it; operands are scrambled right after acceptance.
   task automatic run_long(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           output int busy_cycles, output bit done_ok, output bit stable_ok);
      logic [31:0] hi0, lo0;
      @(negedge Clk);
      Start = 1'b1; Op = op; Rs = a; Rt = b;
      hi0 = HI; lo0 = LO;
      @(posedge Clk); #1;
      Start = 1'b0; Op = 4'd0; Rs = $urandom; Rt = $urandom;
      busy_cycles = 0; done_ok = 1'b0; stable_ok = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge Clk);
         if (Done) begin done_ok = !Busy; break; end
         if (Busy) busy_cycles++;
         if (HI !== hi0 || LO !== lo0) stable_ok = 1'b0;
      end
   endtask

   task automatic issue_short(input logic [3:0] op, input logic [31:0] a);
      @(negedge Clk);
      Start = 1'b1; Op = op; Rs = a;
      @(posedge Clk); #1;
      Start = 1'b0; Op = 4'd0; Rs = $urandom;
   endtask

   task automatic test_reset();
      #2 Rst_n = 1'b0;
      @(negedge Clk);
      Start = 1'b1; Op = 4'd1; Rs = 32'd3; Rt = 32'd3;
      @(negedge Clk);
      Start = 1'b0; Op = 4'd0;
      total_cnt++; if (Busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", Busy); else pass_cnt++;
      total_cnt++; if (Done !== 1'b0) $display("FAIL reset_done: got %b expected 0", Done); else pass_cnt++;
      total_cnt++; if (HI !== 32'h0) $display("FAIL reset_hi: got %h expected 0", HI); else pass_cnt++;
      total_cnt++; if (LO !== 32'h0) $display("FAIL reset_lo: got %h expected 0", LO); else pass_cnt++;
      Rst_n = 1'b1;
      @(negedge Clk);
   endtask

   task automatic test_directed();
      logic [3:0]  ops [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd3};
      logic [31:0] as  [5] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000};
      logic [31:0] bs  [5] = '{32'd5, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'hFFFF_FFFF};
      logic [31:0] ehi [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd7, 32'd0};
      logic [31:0] elo [5] = '{32'hFFFF_FFF1, 32'h0000_0001, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
      int bc;
      bit dok, sok;
      for (int i = 0; i < 5; i++) begin
         run_long(ops[i], as[i], bs[i], bc, dok, sok);
         total_cnt++; if (bc !== 33) $display("FAIL dir_busy_len[%0d]: got %0d expected 33", i, bc); else pass_cnt++;
         total_cnt++; if (!dok) $display("FAIL dir_done[%0d]: got no Done with Busy low, expected one", i); else pass_cnt++;
         total_cnt++; if (!sok) $display("FAIL dir_hilo_stable[%0d]: got HI/LO change while busy, expected none", i); else pass_cnt++;
         total_cnt++; if (HI !== ehi[i]) $display("FAIL dir_hi[%0d]: got %h expected %h", i, HI, ehi[i]); else pass_cnt++;
         total_cnt++; if (LO !== elo[i]) $display("FAIL dir_lo[%0d]: got %h expected %h", i, LO, elo[i]); else pass_cnt++;
         @(negedge Clk);
         total_cnt++; if (Done !== 1'b0) $display("FAIL dir_done_width[%0d]: got %b expected 0", i, Done); else pass_cnt++;
         $display("directed op=%0d rs=%h rt=%h -> hi=%h lo=%h", ops[i], as[i], bs[i], HI, LO);
         m_hi = ehi[i]; m_lo = elo[i];
      end
   endtask

   task automatic test_random();
      logic [3:0]  op;
      logic [31:0] a, b;
      logic [63:0] exp;
      int bc, sel;
      bit dok, sok;
      for (int i = 0; i < 20; i++) begin
         op = 4'($urandom_range(1, 4));
         a = $urandom; b = $urandom;
         sel = $urandom_range(0, 7);
         if (sel == 0) b = 32'd0;
         else if (sel == 1) b = $urandom_range(1, 15);
         else if (sel == 2) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
         exp = ref_long(op, a, b, {m_hi, m_lo});
         run_long(op, a, b, bc, dok, sok);
         total_cnt++; if (!dok || bc != 33) $display("FAIL rnd_timing[%0d]: got busy=%0d done=%b expected busy=33 done=1", i, bc, dok); else pass_cnt++;
         total_cnt++; if ({HI, LO} !== exp) $display("FAIL rnd_result[%0d]: op=%0d rs=%h rt=%h got %h expected %h", i, op, a, b, {HI, LO}, exp); else pass_cnt++;
         $display("random op=%0d rs=%h rt=%h -> hi=%h lo=%h", op, a, b, HI, LO);
         {m_hi, m_lo} = exp;
      end
   endtask

   task automatic test_move();
      issue_short(4'd5, 32'h0000_1234);
      total_cnt++; if (HI !== 32'h1234) $display("FAIL mthi_hi: got %h expected 00001234", HI); else pass_cnt++;
      total_cnt++; if (LO !== m_lo) $display("FAIL mthi_lo: got %h expected %h", LO, m_lo); else pass_cnt++;
      total_cnt++; if (Busy !== 1'b0) $display("FAIL mthi_busy: got %b expected 0", Busy); else pass_cnt++;
      @(negedge Clk);
      total_cnt++; if (Done !== 1'b0) $display("FAIL mthi_done: got %b expected 0", Done); else pass_cnt++;
      m_hi = 32'h1234;
      issue_short(4'd6, 32'hCAFE_0001);
      total_cnt++; if ({HI, LO} !== {m_hi, 32'hCAFE_0001}) $display("FAIL mtlo: got %h expected %h", {HI, LO}, {m_hi, 32'hCAFE_0001}); else pass_cnt++;
      m_lo = 32'hCAFE_0001;
      $display("move hi=%h lo=%h", HI, LO);
   endtask

   task automatic test_nop();
      logic [3:0] codes [3] = '{4'd0, 4'd7, 4'd15};
      for (int i = 0; i < 3; i++) begin
         issue_short(codes[i], 32'h5555_AAAA);
         @(negedge Clk);
         total_cnt++; if (Busy !== 1'b0 || {HI, LO} !== {m_hi, m_lo})
            $display("FAIL nop[%0d]: got busy=%b hilo=%h expected busy=0 hilo=%h", codes[i], Busy, {HI, LO}, {m_hi, m_lo});
         else pass_cnt++;
         $display("nop code=%0d busy=%b", codes[i], Busy);
      end
   endtask

   task automatic test_busy_ignore();
      logic [31:0] a, b;
      logic [63:0] exp;
      bit got_done;
      a = $urandom; b = $urandom;
      exp = ref_long(4'd1, a, b, {m_hi, m_lo});
      @(negedge Clk);
      Start = 1'b1; Op = 4'd1; Rs = a; Rt = b;
      @(posedge Clk); #1;
      Start = 1'b0; Op = 4'd0;
      repeat (5) @(negedge Clk);
      Start = 1'b1; Op = 4'd4; Rs = $urandom; Rt = 32'd3;
      @(negedge Clk);
      Op = 4'd5; Rs = 32'hDEAD_BEEF;
      @(negedge Clk);
      Start = 1'b0; Op = 4'd0;
      got_done = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge Clk);
         if (Done) begin got_done = 1'b1; break; end
      end
      total_cnt++; if (!got_done) $display("FAIL ignore_done: got no Done expected one"); else pass_cnt++;
      total_cnt++; if ({HI, LO} !== exp) $display("FAIL ignore_result: got %h expected %h", {HI, LO}, exp); else pass_cnt++;
      repeat (3) @(negedge Clk);
      total_cnt++; if (Busy !== 1'b0) $display("FAIL ignore_no_restart: got busy=%b expected 0", Busy); else pass_cnt++;
      $display("busy_ignore rs=%h rt=%h -> hi=%h lo=%h", a, b, HI, LO);
      {m_hi, m_lo} = exp;
   endtask

   task automatic test_reset_mid();
      issue_short(4'd5, 32'hA5A5_0000);
      issue_short(4'd6, 32'h0000_5A5A);
      @(negedge Clk);
      Start = 1'b1; Op = 4'd2; Rs = $urandom | 32'h1; Rt = $urandom | 32'h1;
      @(posedge Clk); #1;
      Start = 1'b0; Op = 4'd0;
      repeat (10) @(negedge Clk);
      Rst_n = 1'b0;
      #1;
      total_cnt++; if (Busy !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", Busy); else pass_cnt++;
      total_cnt++; if ({HI, LO} !== 64'h0) $display("FAIL midrst_hilo: got %h expected 0", {HI, LO}); else pass_cnt++;
      @(negedge Clk);
      Rst_n = 1'b1;
      repeat (40) @(negedge Clk);
      total_cnt++; if (Busy !== 1'b0 || {HI, LO} !== 64'h0)
         $display("FAIL midrst_after: got busy=%b hilo=%h expected busy=0 hilo=0", Busy, {HI, LO});
      else pass_cnt++;
      $display("reset_mid busy=%b hi=%h lo=%h", Busy, HI, LO);
      m_hi = '0; m_lo = '0;
   endtask

`ifdef MULDIV_MADD_EN
   task automatic test_madd();
      logic [3:0]  op;
      logic [31:0] a, b;
      logic [63:0] exp;
      int bc;
      bit dok, sok;
      issue_short(4'd5, 32'd0);
      issue_short(4'd6, 32'd10);
      run_long(4'd8, 32'd3, 32'd4, bc, dok, sok);
      total_cnt++; if (!dok || bc != 33) $display("FAIL madd_timing: got busy=%0d done=%b expected 33/1", bc, dok); else pass_cnt++;
      total_cnt++; if ({HI, LO} !== {32'd0, 32'd22}) $display("FAIL madd_result: got %h expected %h", {HI, LO}, {32'd0, 32'd22}); else pass_cnt++;
      run_long(4'd11, 32'd1, 32'd23, bc, dok, sok);
      total_cnt++; if ({HI, LO} !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL msubu_result: got %h expected ffffffffffffffff", {HI, LO}); else pass_cnt++;
      $display("madd/msubu -> hi=%h lo=%h", HI, LO);
      m_hi = HI; m_lo = LO;
      m_hi = 32'hFFFF_FFFF; m_lo = 32'hFFFF_FFFF;
      for (int i = 0; i < 6; i++) begin
         op = 4'($urandom_range(8, 11));
         a = $urandom; b = $urandom;
         exp = ref_long(op, a, b, {m_hi, m_lo});
         run_long(op, a, b, bc, dok, sok);
         total_cnt++; if ({HI, LO} !== exp) $display("FAIL macc_rnd[%0d]: op=%0d got %h expected %h", i, op, {HI, LO}, exp); else pass_cnt++;
         $display("macc op=%0d rs=%h rt=%h -> hi=%h lo=%h", op, a, b, HI, LO);
         {m_hi, m_lo} = exp;
      end
   endtask
`else
   task automatic test_madd();
      for (int c = 8; c < 12; c++) begin
         issue_short(4'(c), 32'h1111_2222);
         @(negedge Clk);
         total_cnt++; if (Busy !== 1'b0 || {HI, LO} !== {m_hi, m_lo})
            $display("FAIL macc_nop[%0d]: got busy=%b hilo=%h expected busy=0 hilo=%h", c, Busy, {HI, LO}, {m_hi, m_lo});
         else pass_cnt++;
         $display("macc code=%0d treated as nop busy=%b", c, Busy);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_directed();
      test_move();
      test_nop();
      test_random();
      test_busy_ignore();
      test_reset_mid();
      test_madd();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, passed %0d of %0d", pass_cnt, total_cnt);
      $fatal(1);
   end
endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- EX-stage multiply/divide unit, directly downstream of the ID/EX pipeline register.
- Consumes the operand pair and the decoded mul/div opcode latched by ID/EX.
- Performs iterative signed/unsigned multiply and divide into the architectural HI/LO registers.
- Drives Busy to the hazard unit so that a following mul/div/MFHI/MFLO is stalled until HI/LO are final.

Parameters:
WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.

Ports:
Clk  input  1  pipeline clock, rising edge
Rst_n  input  1  asynchronous active-low reset
Start  input  1  issue strobe from EX control, valid for one cycle per instruction
Op  input  4  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 8 MADD, 9 MADDU, 10 MSUB, 11 MSUBU; others NOP
Rs  input  WIDTH  EX_Read1 (multiplicand / dividend / MTHI-MTLO source)
Rt  input  WIDTH  EX_Read2 (multiplier / divisor)
Busy  output  1  operation in flight; the hazard unit stalls dependent instructions
Done  output  1  one-cycle pulse on the cycle HI/LO become final
HI  output  WIDTH  HI register, registered, read directly for MFHI
LO  output  WIDTH  LO register, registered, read directly for MFLO

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Reset values: Busy=0, Done=0, HI=0, LO=0, FSM=IDLE. All internal accumulators are cleared.
- Reset asserted mid-operation aborts the operation immediately; HI/LO read 0 afterwards.
- FSM states:
  - IDLE: waiting for an issue.
  - RUN: counter 0..WIDTH-1, one shift-add (multiply) or one restoring subtract-shift (divide) per cycle.
  - FIX: sign correction and HI/LO write.
- Acceptance: Start=1 on edge T while in IDLE.
  - Long ops (MULT/MULTU/DIV/DIVU): latch operand magnitudes, sign flags and op at T, then go to RUN.
  - Busy is 1 from after T through edge T+WIDTH+1, i.e. 33 cycles at WIDTH=32.
  - RUN occupies edges T+1..T+WIDTH; FIX writes HI/LO at edge T+WIDTH+1, which also returns the FSM to IDLE.
  - Done=1 for exactly the cycle after that edge. Busy drops in the same cycle.
- MTHI/MTLO: single-cycle ops. HI<=Rs or LO<=Rs at edge T. Busy and Done stay 0.
- NOP or an unused code with Start=1: no state change.
- Start while Busy=1: ignored. HI/LO and the in-flight op are unaffected; the hazard unit must hold the issuing instruction.
- Multiply result:
  - {HI,LO} holds the 2*WIDTH-bit product.
  - Signed ops multiply magnitudes and negate the 64-bit result in FIX when the operand signs differ.
- Divide result: LO=quotient, HI=remainder.
  - Signed divide truncates toward zero; the remainder takes the dividend's sign.
  - Divide by zero, signed or unsigned: LO=all ones, HI=Rs as latched at T.
  - Signed overflow (Rs=0x80000000, Rt=0xFFFFFFFF): LO=0x80000000, HI=0.
- Operands are latched at T. Changes on Rs/Rt during RUN have no effect.
- HI and LO change only at the FIX edge, an MTHI/MTLO edge, or reset. They never hold partial values while Busy=1.

Optional Feature:
- Macro: MULDIV_MADD_EN.
- Defined:
  - Ops 8-11 run the long multiply path, then FIX writes {HI,LO} <= {HI,LO} +/- product, modulo 2^(2*WIDTH).
  - Signedness follows MADD/MSUB (signed) and MADDU/MSUBU (unsigned).
  - Same 33-cycle Busy window.
- Not defined: codes 8-11 decode as NOP with no Busy, and no accumulator adder is synthesised.

Test Plan:
- Reset release, then MULT Rs=0xFFFFFFFD (-3), Rt=5 -> Busy high 33 cycles; Done pulse; HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- MULTU Rs=0xFFFFFFFF, Rt=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV Rs=-7, Rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIVU Rs=7, Rt=0 -> LO=0xFFFFFFFF, HI=0x00000007.
- DIV Rs=0x80000000, Rt=0xFFFFFFFF -> LO=0x80000000, HI=0. Then MTHI Rs=0x1234 -> HI=0x1234 next edge, Busy stays 0.
- MULT issued, then Start=1 with DIVU on cycle 5 of Busy -> DIVU ignored; final HI/LO equal the MULT result. Rst_n pulled low at cycle 10 of a fresh op -> Busy=0, HI=LO=0 immediately.
- With MULDIV_MADD_EN defined: MTHI 0, MTLO 10, then MADD Rs=3, Rt=4 -> HI=0, LO=22; MSUBU Rs=1, Rt=23 -> HI=0xFFFFFFFF, LO=0xFFFFFFFF.
